// File: rtl/multicycle_seq_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, decode classes,
// RV32 opcodes and branch funct3 values.
package multicycle_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_ILLEGAL
  } class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic class_e decode_class(input logic [6:0] op);
    case (op)
      OP_R, OP_IALU, OP_LUI, OP_AUIPC: return CL_ALU;
      OP_LOAD:                         return CL_LOAD;
      OP_STORE:                        return CL_STORE;
      OP_BRANCH:                       return CL_BRANCH;
      OP_JAL, OP_JALR:                 return CL_JUMP;
      default:                         return CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_seq_if.sv
// Unified memory port handshake shared by instruction fetch and load/store.
interface multicycle_seq_if;
  logic mem_req;
  logic mem_we;
  logic IorD;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output IorD, input mem_ready);
  modport slave  (input mem_req, input mem_we, input IorD, output mem_ready);
endinterface

// File: rtl/multicycle_seq_branch_resolve.sv
// Branch condition from funct3 and the datapath comparator; purely combinational.
module branch_resolve
  import multicycle_seq_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:           taken = BrEq;
      F3_BNE:           taken = !BrEq;
      F3_BLT, F3_BLTU:  taken = BrLT;
      F3_BGE, F3_BGEU:  taken = !BrLT;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
// Optional perf counters (cycle_cnt, instret_cnt) under `MULTICYCLE_PERF_EN.
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              BrEq,
  input  logic              BrLT,
  multicycle_seq_if.master  mem,
  output logic              ir_we,
  output logic              pc_we,
  output logic              PCSel,
  output logic              RegWEn,
  output logic [2:0]        state,
  output logic              trap
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  state_e          state_q, state_d;
  class_e          cls_q, cls_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            br_taken, br_illegal;
  logic            mem_phase, to_hit, live;

  branch_resolve u_br (
    .funct3  (funct3),
    .BrEq    (BrEq),
    .BrLT    (BrLT),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign to_hit    = (to_q == TO_W'(MEM_TIMEOUT));

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    to_d    = to_q;
    case (state_q)
      ST_FETCH: begin
        if (mem.mem_ready) state_d = ST_DECODE;
        else if (to_hit)   state_d = ST_TRAP;
      end
      ST_DECODE: begin
        cls_d   = decode_class(opcode);
        state_d = (cls_d == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_BRANCH:         state_d = br_illegal ? ST_TRAP : ST_FETCH;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem.mem_ready) state_d = (cls_q == CL_LOAD) ? ST_WB : ST_FETCH;
        else if (to_hit)   state_d = ST_TRAP;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
    // Counter measures only the current wait; any transition restarts it.
    if (state_d != state_q)                to_d = '0;
    else if (mem_phase && !mem.mem_ready)  to_d = to_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cls_q   <= CL_ALU;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      to_q    <= to_d;
    end
  end

  // Outputs decode registered state; rst masks them so a reset cycle can
  // never complete a store, write the register file or step the PC.
  assign live     = !rst;
  assign mem.mem_req = live && mem_phase;
  assign mem.IorD    = live && (state_q == ST_MEM);
  assign mem.mem_we  = live && (state_q == ST_MEM) && (cls_q == CL_STORE);
  assign ir_we    = live && (state_q == ST_FETCH) && mem.mem_ready;
  assign RegWEn   = live && (state_q == ST_WB);
  assign trap     = live && (state_q == ST_TRAP);
  assign state    = state_q;

  always_comb begin
    pc_we = 1'b0;
    PCSel = 1'b0;
    if (live) begin
      case (state_q)
        ST_EXEC: begin
          if (cls_q == CL_BRANCH && !br_illegal) begin
            pc_we = 1'b1;
            PCSel = br_taken;
          end
        end
        ST_MEM: pc_we = (cls_q == CL_STORE) && mem.mem_ready;
        ST_WB: begin
          pc_we = 1'b1;
          PCSel = (cls_q == CL_JUMP);
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != ST_TRAP) cyc_q <= cyc_q + 32'd1;
      if (pc_we)              ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ins_q;
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench: each stimulus cycle pushes its expected outputs into a
// scoreboard queue; a negedge monitor pops and compares.
module tb_multicycle_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       BrEq, BrLT;
  logic       ir_we, pc_we, PCSel, RegWEn, trap;
  logic [2:0] state;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_seq_if mif ();

  multicycle_seq #(.MEM_TIMEOUT(15), .TO_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .funct3 (funct3),
    .BrEq   (BrEq),
    .BrLT   (BrLT),
    .mem    (mif),
    .ir_we  (ir_we),
    .pc_we  (pc_we),
    .PCSel  (PCSel),
    .RegWEn (RegWEn),
    .state  (state),
    .trap   (trap)
`ifdef MULTICYCLE_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output flags: {mem_req, IorD, mem_we, ir_we, pc_we, PCSel, RegWEn, trap}
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_FDONE = 8'b1001_0000;
  localparam logic [7:0] O_FWAIT = 8'b1000_0000;
  localparam logic [7:0] O_LDMEM = 8'b1100_0000;
  localparam logic [7:0] O_STW   = 8'b1110_0000;
  localparam logic [7:0] O_STD   = 8'b1110_1000;
  localparam logic [7:0] O_WB    = 8'b0000_1010;
  localparam logic [7:0] O_WBJ   = 8'b0000_1110;
  localparam logic [7:0] O_BRT   = 8'b0000_1100;
  localparam logic [7:0] O_BRN   = 8'b0000_1000;
  localparam logic [7:0] O_TRAP  = 8'b0000_0001;

  string       nmq[$];
  logic [10:0] vq[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  logic [6:0] p_op;
  logic [2:0] p_f3;
  logic       p_eq, p_lt;

  task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                       input logic eq, input logic lt);
    p_op = op; p_f3 = f3; p_eq = eq; p_lt = lt;
  endtask

  task automatic step(input string nm, input logic r, input logic rdy,
                      input logic [2:0] st, input logic [7:0] f);
    @(posedge clk);
    #1;
    rst           = r;
    mif.mem_ready = rdy;
    opcode        = p_op;
    funct3        = p_f3;
    BrEq          = p_eq;
    BrLT          = p_lt;
    nmq.push_back(nm);
    vq.push_back({st, f});
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (vq.size() > 0) begin
        string       nm;
        logic [10:0] ev, av;
        nm = nmq.pop_front();
        ev = vq.pop_front();
        av = {state, mif.mem_req, mif.IorD, mif.mem_we, ir_we, pc_we, PCSel, RegWEn, trap};
        n_chk++;
        if (av === ev) n_pass++;
        else $display("FAIL %s: got state=%0d flags=%b, expected state=%0d flags=%b",
                      nm, av[10:8], av[7:0], ev[10:8], ev[7:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mif.mem_ready = 1'b0;
    opcode = '0; funct3 = '0; BrEq = 1'b0; BrLT = 1'b0;
    instr(7'h00, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    step("reset", 1, 0, 3'd0, O_IDLE);
    step("reset2", 1, 1, 3'd0, O_IDLE);

    // add, zero-wait memory: 0,1,2,4
    instr(7'b0110011, 3'd0, 1'b0, 1'b0);
    step("add_F", 0, 1, 3'd0, O_FDONE);
    step("add_D", 0, 1, 3'd1, O_IDLE);
    step("add_E", 0, 1, 3'd2, O_IDLE);
    step("add_W", 0, 1, 3'd4, O_WB);

    // lw with three MEM wait cycles: 8 cycles total
    instr(7'b0000011, 3'd2, 1'b0, 1'b0);
    step("lw_F", 0, 1, 3'd0, O_FDONE);
    step("lw_D", 0, 1, 3'd1, O_IDLE);
    step("lw_E", 0, 0, 3'd2, O_IDLE);
    step("lw_M0", 0, 0, 3'd3, O_LDMEM);
    step("lw_M1", 0, 0, 3'd3, O_LDMEM);
    step("lw_M2", 0, 0, 3'd3, O_LDMEM);
    step("lw_M3", 0, 1, 3'd3, O_LDMEM);
    step("lw_W", 0, 0, 3'd4, O_WB);

    // bne not-equal -> taken
    instr(7'b1100011, 3'b001, 1'b0, 1'b0);
    step("bne0_F", 0, 1, 3'd0, O_FDONE);
    step("bne0_D", 0, 1, 3'd1, O_IDLE);
    step("bne0_E", 0, 1, 3'd2, O_BRT);
    // bne equal -> not taken
    instr(7'b1100011, 3'b001, 1'b1, 1'b0);
    step("bne1_F", 0, 1, 3'd0, O_FDONE);
    step("bne1_D", 0, 1, 3'd1, O_IDLE);
    step("bne1_E", 0, 1, 3'd2, O_BRN);
    // beq equal -> taken
    instr(7'b1100011, 3'b000, 1'b1, 1'b0);
    step("beq_F", 0, 1, 3'd0, O_FDONE);
    step("beq_D", 0, 1, 3'd1, O_IDLE);
    step("beq_E", 0, 1, 3'd2, O_BRT);
    // blt less-than -> taken
    instr(7'b1100011, 3'b100, 1'b0, 1'b1);
    step("blt_F", 0, 1, 3'd0, O_FDONE);
    step("blt_D", 0, 1, 3'd1, O_IDLE);
    step("blt_E", 0, 1, 3'd2, O_BRT);
    // bgeu less-than -> not taken
    instr(7'b1100011, 3'b111, 1'b0, 1'b1);
    step("bgeu_F", 0, 1, 3'd0, O_FDONE);
    step("bgeu_D", 0, 1, 3'd1, O_IDLE);
    step("bgeu_E", 0, 1, 3'd2, O_BRN);

    // jal: WB writes link and redirects PC
    instr(7'b1101111, 3'd0, 1'b0, 1'b0);
    step("jal_F", 0, 1, 3'd0, O_FDONE);
    step("jal_D", 0, 1, 3'd1, O_IDLE);
    step("jal_E", 0, 1, 3'd2, O_IDLE);
    step("jal_W", 0, 1, 3'd4, O_WBJ);

    // sw, zero-wait: 4 cycles
    instr(7'b0100011, 3'd2, 1'b0, 1'b0);
    step("sw_F", 0, 1, 3'd0, O_FDONE);
    step("sw_D", 0, 1, 3'd1, O_IDLE);
    step("sw_E", 0, 1, 3'd2, O_IDLE);
    step("sw_M", 0, 1, 3'd3, O_STD);

    // branch with reserved funct3 -> TRAP
    instr(7'b1100011, 3'b010, 1'b0, 1'b0);
    step("brill_F", 0, 1, 3'd0, O_FDONE);
    step("brill_D", 0, 1, 3'd1, O_IDLE);
    step("brill_E", 0, 1, 3'd2, O_IDLE);
    step("brill_T", 0, 1, 3'd5, O_TRAP);
    step("brill_R", 1, 0, 3'd5, O_IDLE);

    // opcode 0x7F -> TRAP, sticky, no mem_req despite mem_ready
    instr(7'h7F, 3'd0, 1'b0, 1'b0);
    step("ill_F", 0, 1, 3'd0, O_FDONE);
    step("ill_D", 0, 1, 3'd1, O_IDLE);
    for (int i = 0; i < 4; i++) step("ill_T", 0, 1, 3'd5, O_TRAP);
    step("ill_R", 1, 1, 3'd5, O_IDLE);

    // fetch timeout: 15 wait cycles reach the limit, next miss traps
    instr(7'b0110011, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("to_wait", 0, 0, 3'd0, O_FWAIT);
    step("to_T0", 0, 1, 3'd5, O_TRAP);
    step("to_T1", 0, 0, 3'd5, O_TRAP);
    step("to_R", 1, 0, 3'd5, O_IDLE);

    // ready arrives on the cycle the limit is reached -> completes
    for (int i = 0; i < 15; i++) step("tos_wait", 0, 0, 3'd0, O_FWAIT);
    step("tos_F", 0, 1, 3'd0, O_FDONE);
    step("tos_D", 0, 0, 3'd1, O_IDLE);
    step("tos_E", 0, 0, 3'd2, O_IDLE);
    step("tos_W", 0, 0, 3'd4, O_WB);

    // sw with rst during MEM: no store, no PC step
    instr(7'b0100011, 3'd2, 1'b0, 1'b0);
    step("swr_F", 0, 1, 3'd0, O_FDONE);
    step("swr_D", 0, 1, 3'd1, O_IDLE);
    step("swr_E", 0, 0, 3'd2, O_IDLE);
    step("swr_M", 0, 0, 3'd3, O_STW);
    step("swr_R", 1, 1, 3'd3, O_IDLE);
    step("swr_F2", 0, 0, 3'd0, O_FWAIT);

    // recovery: lui runs normally
    instr(7'b0110111, 3'd0, 1'b0, 1'b0);
    step("lui_F", 0, 1, 3'd0, O_FDONE);
    step("lui_D", 0, 1, 3'd1, O_IDLE);
    step("lui_E", 0, 1, 3'd2, O_IDLE);
    step("lui_W", 0, 1, 3'd4, O_WB);

    repeat (3) @(posedge clk);
    if (vq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, expected 0", vq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
